// File: rtl/execute_y_pipe.sv
// execute_y_pipe
// ----------------------------------------------------------------------------
// Purpose: fixed-latency multiply pipe ("Y" execution unit). Each accepted op
// travels through STAGES registered stages. It reaches writeback STAGES-1
// edges after the edge that accepted it, unless the output is stalled.
// Supported ops: MUL (low half), MULH (s*s high), MULHU (u*u high) and
// MULHSU (s*u high).
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   is_y_valid       issue presents an op
//   is_y_op          00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
//   is_y_rega/regb   operands A / B (WIDTH bits)
//   is_y_regdest     destination register index (REGBITS bits)
//   is_y_writereg    op writes a register
//   y_is_ready       pipe accepts an op this cycle
//   is_y_checkreg    register queried by issue for a hazard check
//   y_is_hazard      checkreg is a pending destination somewhere in the pipe
//   flush            discard every in-flight op and any same-cycle issue
//   wb_y_stall       writeback cannot take the output this cycle
//   y_wb_valid       result present at the output
//   y_wb_regdest     result destination (0 when no result)
//   y_wb_writereg    result writes the register file (0 when no result)
//   y_wb_wbvalue     result value (0 when no result)
// ----------------------------------------------------------------------------
module execute_y_pipe #(
  parameter int WIDTH   = 32,
  parameter int STAGES  = 4,
  parameter int REGBITS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               is_y_valid,
  input  logic [1:0]         is_y_op,
  input  logic [WIDTH-1:0]   is_y_rega,
  input  logic [WIDTH-1:0]   is_y_regb,
  input  logic [REGBITS-1:0] is_y_regdest,
  input  logic               is_y_writereg,
  output logic               y_is_ready,
  input  logic [REGBITS-1:0] is_y_checkreg,
  output logic               y_is_hazard,
  input  logic               flush,
  input  logic               wb_y_stall,
  output logic               y_wb_valid,
  output logic [REGBITS-1:0] y_wb_regdest,
  output logic               y_wb_writereg,
  output logic [WIDTH-1:0]   y_wb_wbvalue
);

  localparam int LAST = STAGES - 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b11;

  // Stage 0 holds the raw operands; the product is formed between stage 0
  // and stage 1, and later stages only carry the selected result.
  logic [STAGES-1:0]  r_valid;
  logic [STAGES-1:0]  r_wr;
  logic [REGBITS-1:0] r_dest [0:LAST];
  logic [1:0]         r_op0;
  logic [WIDTH-1:0]   r_a0;
  logic [WIDTH-1:0]   r_b0;
  logic [WIDTH-1:0]   r_val [1:LAST];

  logic               w_hold;
  logic               w_issue_wr;
  logic               w_a_sign;
  logic               w_b_sign;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_result;
  logic               w_hazard_any;

  // The whole pipe freezes only when a real result sits at the output and
  // writeback refuses it; a bubble at the output never holds anything back.
  assign w_hold     = r_valid[LAST] & wb_y_stall;
  assign y_is_ready = ~w_hold;

  // Register-file write is suppressed for destination 0 at issue time, so the
  // flag carried down the pipe is already the final writeback qualifier.
  assign w_issue_wr = is_y_writereg & (is_y_regdest != {REGBITS{1'b0}});

  // Operand sign extension and 2*WIDTH product; the low 2*WIDTH bits of the
  // extended product are exact for every signedness combination.
  always_comb begin
    w_a_sign = 1'b0;
    w_b_sign = 1'b0;
    case (r_op0)
      OP_MULH: begin
        w_a_sign = r_a0[WIDTH-1];
        w_b_sign = r_b0[WIDTH-1];
      end
      OP_MULHSU: begin
        w_a_sign = r_a0[WIDTH-1];
        w_b_sign = 1'b0;
      end
      default: begin
        w_a_sign = 1'b0;
        w_b_sign = 1'b0;
      end
    endcase
    w_a_ext = {{WIDTH{w_a_sign}}, r_a0};
    w_b_ext = {{WIDTH{w_b_sign}}, r_b0};
    w_prod  = w_a_ext * w_b_ext;
    if (r_op0 == OP_MUL) begin
      w_result = w_prod[WIDTH-1:0];
    end else begin
      w_result = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Scan every stage, output stage included, for a pending write to checkreg.
  always_comb begin
    w_hazard_any = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (r_valid[i] && r_wr[i] && (r_dest[i] == is_y_checkreg)) begin
        w_hazard_any = 1'b1;
      end else begin
        w_hazard_any = w_hazard_any;
      end
    end
  end

  assign y_is_hazard = w_hazard_any & (is_y_checkreg != {REGBITS{1'b0}});

  // Stage registers: clear on reset/flush, shift when not held, else freeze.
  // Payload fields are zeroed whenever a stage receives a bubble so that the
  // output stage can drive the writeback ports directly.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid <= {STAGES{1'b0}};
      r_wr    <= {STAGES{1'b0}};
      r_op0   <= 2'b00;
      r_a0    <= {WIDTH{1'b0}};
      r_b0    <= {WIDTH{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        r_dest[i] <= {REGBITS{1'b0}};
      end
      for (int i = 1; i < STAGES; i++) begin
        r_val[i] <= {WIDTH{1'b0}};
      end
    end else if (!w_hold) begin
      r_valid <= {r_valid[STAGES-2:0], is_y_valid};
      if (is_y_valid) begin
        r_wr[0]   <= w_issue_wr;
        r_dest[0] <= is_y_regdest;
        r_op0     <= is_y_op;
        r_a0      <= is_y_rega;
        r_b0      <= is_y_regb;
      end else begin
        r_wr[0]   <= 1'b0;
        r_dest[0] <= {REGBITS{1'b0}};
        r_op0     <= 2'b00;
        r_a0      <= {WIDTH{1'b0}};
        r_b0      <= {WIDTH{1'b0}};
      end
      if (r_valid[0]) begin
        r_wr[1]   <= r_wr[0];
        r_dest[1] <= r_dest[0];
        r_val[1]  <= w_result;
      end else begin
        r_wr[1]   <= 1'b0;
        r_dest[1] <= {REGBITS{1'b0}};
        r_val[1]  <= {WIDTH{1'b0}};
      end
      for (int i = 2; i < STAGES; i++) begin
        if (r_valid[i-1]) begin
          r_wr[i]   <= r_wr[i-1];
          r_dest[i] <= r_dest[i-1];
          r_val[i]  <= r_val[i-1];
        end else begin
          r_wr[i]   <= 1'b0;
          r_dest[i] <= {REGBITS{1'b0}};
          r_val[i]  <= {WIDTH{1'b0}};
        end
      end
    end else begin
      // Output stalled with a live result: every stage keeps its contents.
      r_valid <= r_valid;
    end
  end

  assign y_wb_valid    = r_valid[LAST];
  assign y_wb_writereg = r_wr[LAST];
  assign y_wb_regdest  = r_dest[LAST];
  assign y_wb_wbvalue  = r_val[LAST];

endmodule

// File: tb/tb_execute_y_pipe.sv
// tb_execute_y_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for execute_y_pipe (WIDTH=32, STAGES=4, REGBITS=5).
// Reference model: a queue of in-flight ops, each with its age in cycles.
// An op is at the output once its age reaches STAGES-1. Ages advance every
// cycle except when the output op is stalled. Results come from plain 64-bit
// arithmetic.
// ----------------------------------------------------------------------------
module tb_execute_y_pipe;

  localparam int WIDTH   = 32;
  localparam int STAGES  = 4;
  localparam int REGBITS = 5;

  logic               clock = 1'b0;
  logic               reset;
  logic               is_y_valid;
  logic [1:0]         is_y_op;
  logic [WIDTH-1:0]   is_y_rega;
  logic [WIDTH-1:0]   is_y_regb;
  logic [REGBITS-1:0] is_y_regdest;
  logic               is_y_writereg;
  logic               y_is_ready;
  logic [REGBITS-1:0] is_y_checkreg;
  logic               y_is_hazard;
  logic               flush;
  logic               wb_y_stall;
  logic               y_wb_valid;
  logic [REGBITS-1:0] y_wb_regdest;
  logic               y_wb_writereg;
  logic [WIDTH-1:0]   y_wb_wbvalue;

  always #5 clock = ~clock;

  execute_y_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .REGBITS(REGBITS)) dut (
    .clock(clock), .reset(reset),
    .is_y_valid(is_y_valid), .is_y_op(is_y_op),
    .is_y_rega(is_y_rega), .is_y_regb(is_y_regb),
    .is_y_regdest(is_y_regdest), .is_y_writereg(is_y_writereg),
    .y_is_ready(y_is_ready), .is_y_checkreg(is_y_checkreg),
    .y_is_hazard(y_is_hazard), .flush(flush), .wb_y_stall(wb_y_stall),
    .y_wb_valid(y_wb_valid), .y_wb_regdest(y_wb_regdest),
    .y_wb_writereg(y_wb_writereg), .y_wb_wbvalue(y_wb_wbvalue)
  );

  typedef struct {
    logic [REGBITS-1:0] dest;
    logic               wr;
    logic [WIDTH-1:0]   val;
    int                 age;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic             use_cexp = 1'b0;
  logic [WIDTH-1:0] cexp     = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint pa;
    longint pb;
    longint p;
    pa = (op == 2'b01 || op == 2'b11) ? longint'($signed(a)) : longint'({32'd0, a});
    pb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = pa * pb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One cycle: compare at negedge, advance the model, cross the posedge.
  task automatic step();
    logic exp_v;
    logic exp_rdy;
    logic exp_hz;
    ent_t e;
    @(negedge clock);
    exp_v   = (q.size() > 0) && (q[0].age == STAGES - 1);
    exp_rdy = !(exp_v && wb_y_stall);
    exp_hz  = 1'b0;
    foreach (q[i]) begin
      if (q[i].wr && q[i].dest == is_y_checkreg && is_y_checkreg != 5'd0) exp_hz = 1'b1;
    end
    check_eq("valid", {31'd0, y_wb_valid}, {31'd0, exp_v});
    check_eq("ready", {31'd0, y_is_ready}, {31'd0, exp_rdy});
    check_eq("hazard", {31'd0, y_is_hazard}, {31'd0, exp_hz});
    if (exp_v) begin
      check_eq("dest", {27'd0, y_wb_regdest}, {27'd0, q[0].dest});
      check_eq("wr", {31'd0, y_wb_writereg}, {31'd0, q[0].wr});
      check_eq("value", y_wb_wbvalue, q[0].val);
    end else begin
      check_eq("dest0", {27'd0, y_wb_regdest}, 32'd0);
      check_eq("wr0", {31'd0, y_wb_writereg}, 32'd0);
      check_eq("value0", y_wb_wbvalue, 32'd0);
    end
    if (reset || flush) begin
      q.delete();
    end else if (exp_rdy) begin
      if (exp_v) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (is_y_valid) begin
        e.dest = is_y_regdest;
        e.wr   = is_y_writereg && (is_y_regdest != 5'd0);
        e.val  = use_cexp ? cexp : ref_mul(is_y_op, is_y_rega, is_y_regb);
        e.age  = 0;
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic wr);
    is_y_valid    = 1'b1;
    is_y_op       = op;
    is_y_rega     = a;
    is_y_regb     = b;
    is_y_regdest  = dest;
    is_y_writereg = wr;
  endtask

  task automatic idle();
    is_y_valid    = 1'b0;
    is_y_op       = 2'($urandom_range(3, 0));
    is_y_rega     = $urandom;
    is_y_regb     = $urandom;
    is_y_regdest  = 5'($urandom_range(31, 0));
    is_y_writereg = 1'b1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] c21 [4];

  initial begin
    reset = 1'b1; flush = 1'b0; wb_y_stall = 1'b0; is_y_checkreg = 5'd0;
    idle();
    @(posedge clock);
    #1;
    repeat (2) step();
    reset = 1'b0;

    // MUL 7*6 -> 42 to r3, then hazard on r5 while an op to r5 is in flight
    use_cexp = 1'b1; cexp = 32'd42;
    drive(2'b00, 32'd7, 32'd6, 5'd3, 1'b1);
    step();
    use_cexp = 1'b0;
    idle();
    repeat (5) step();
    is_y_checkreg = 5'd5;
    drive(2'b01, 32'd3, 32'd9, 5'd5, 1'b1);
    step();
    idle();
    repeat (5) step();
    is_y_checkreg = 5'd0;
    drive(2'b00, 32'd3, 32'd9, 5'd5, 1'b1);
    step();
    idle();
    is_y_checkreg = 5'd0;
    drive(2'b00, 32'd3, 32'd9, 5'd0, 1'b1);
    step();
    idle();
    repeat (5) step();

    // All four ops on A=-1, B=2 with literal expected results
    c21[0] = 32'hFFFF_FFFE; c21[1] = 32'hFFFF_FFFF; c21[2] = 32'h0000_0001; c21[3] = 32'hFFFF_FFFF;
    use_cexp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cexp = c21[k];
      drive(2'(k), 32'hFFFF_FFFF, 32'h0000_0002, 5'(k + 6), 1'b1);
      step();
    end
    use_cexp = 1'b0;
    idle();
    repeat (5) step();

    // Four back-to-back ops, writeback stalled 3 cycles once op1 is at output
    for (int k = 1; k <= 4; k++) begin
      drive(2'b00, 32'(k * 100), 32'd3, 5'(k), 1'b1);
      step();
    end
    idle();
    wb_y_stall = 1'b1;
    repeat (3) step();
    wb_y_stall = 1'b0;
    repeat (6) step();

    // Flush with three ops in flight and a simultaneous issue
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 32'($urandom), 32'($urandom), 5'(k + 10), 1'b1);
      step();
    end
    flush = 1'b1;
    drive(2'b00, 32'd5, 32'd5, 5'd13, 1'b1);
    step();
    flush = 1'b0;
    drive(2'b00, 32'd11, 32'd13, 5'd14, 1'b1);
    step();
    idle();
    repeat (5) step();

    // Reset while stalled with a full pipe
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'($urandom), 32'($urandom), 5'(k + 20), 1'b1);
      step();
    end
    idle();
    wb_y_stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wb_y_stall = 1'b0;
    repeat (6) step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99, 0) < 70) begin
        drive(2'($urandom_range(3, 0)), pick_operand(), pick_operand(),
              5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      end else begin
        idle();
      end
      is_y_checkreg = 5'($urandom_range(7, 0));
      wb_y_stall    = ($urandom_range(99, 0) < 30);
      flush         = ($urandom_range(99, 0) < 3);
      reset         = ($urandom_range(99, 0) < 1);
      step();
    end
    reset = 1'b0; flush = 1'b0; wb_y_stall = 1'b0;
    idle();
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
